// File: rtl/multi_ball_engine.sv
// Multi-ball game core: N balls bounce off the screen edges and wall pixels.
// Wall hits score BCD points and left-edge misses cost lives. Positions update once per frame.
module multi_ball_engine #(
  parameter int unsigned N_BALLS      = 4,
  parameter int unsigned H_RES        = 1024,
  parameter int unsigned V_RES        = 768,
  parameter int unsigned BALL_SIZE    = 16,
  parameter int unsigned STEP         = 2,
  parameter int unsigned SCORE_DIGITS = 4,
  parameter int unsigned LIVES        = 3
) (
  input  logic                      i_clk75MHz,
  input  logic                      i_reset,
  input  logic [10:0]               i_pix_x,
  input  logic [9:0]                i_pix_y,
  input  logic                      i_visible,
  input  logic                      i_vsync,
  input  logic                      i_wall_pix,
  input  logic [N_BALLS-1:0]        i_ball_en,
  input  logic                      i_restart,
  output logic                      o_ball_pix,
  output logic [2:0]                o_ball_idx,
  output logic                      o_hit,
  output logic [4*SCORE_DIGITS-1:0] o_score,
  output logic [3:0]                o_lives,
  output logic                      o_game_over,
  output logic                      o_busy
);
  localparam logic signed [11:0] SX         = 12'(STEP);
  localparam logic signed [11:0] X_MAX      = 12'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] SY         = 11'(STEP);
  localparam logic signed [10:0] Y_MAX      = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0]        X_INIT     = 11'(H_RES / 2);
  localparam logic [3:0]         LIVES_INIT = 4'(LIVES);

  typedef enum logic [1:0] {StIdle, StUpdate, StOver} state_e;

  state_e r_state, w_state_nxt;

  logic [10:0]               r_x [N_BALLS];
  logic [9:0]                r_y [N_BALLS];
  logic [N_BALLS-1:0]        r_dx_neg, r_dy_neg, r_flag;
  logic [2:0]                r_idx;
  logic                      r_vs;
  logic [3:0]                r_lives;
  logic [4*SCORE_DIGITS-1:0] r_score;
  logic                      r_ball_pix;
  logic [2:0]                r_ball_idx;

  logic                      w_tick, w_last, w_init;
  logic                      w_sel_en, w_sel_flag, w_sel_dxn, w_sel_dyn;
  logic [10:0]               w_sel_x;
  logic [9:0]                w_sel_y;
  logic                      w_miss, w_bounce, w_dxn_nxt, w_dyn_nxt;
  logic signed [11:0]        w_nx;
  logic signed [10:0]        w_ny;
  logic [4*SCORE_DIGITS-1:0] w_score_inc;
  logic                      w_carry;
  logic [N_BALLS-1:0]        w_inside;
  logic                      w_draw;
  logic [2:0]                w_draw_idx;

  function automatic logic [9:0] y_init(input int i);
    return 10'(64 + 128 * i);
  endfunction

  always_comb begin
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_en   = 1'b0;
    w_sel_flag = 1'b0;
    w_sel_dxn  = 1'b0;
    w_sel_dyn  = 1'b0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (r_idx == 3'(i)) begin
        w_sel_x    = r_x[i];
        w_sel_y    = r_y[i];
        w_sel_en   = i_ball_en[i];
        w_sel_flag = r_flag[i];
        w_sel_dxn  = r_dx_neg[i];
        w_sel_dyn  = r_dy_neg[i];
      end
    end
  end

  // Miss outranks a pending wall hit; edge clamps act on the moved position.
  always_comb begin
    w_miss    = w_sel_dxn && (w_sel_x <= 11'(STEP));
    w_bounce  = !w_miss && w_sel_flag;
    w_dxn_nxt = w_sel_dxn ^ w_bounce;
    w_dyn_nxt = w_sel_dyn;
    w_nx      = $signed({1'b0, w_sel_x}) + (w_dxn_nxt ? -SX : SX);
    w_ny      = $signed({1'b0, w_sel_y}) + (w_sel_dyn ? -SY : SY);
    if (w_nx >= X_MAX) begin
      w_nx      = X_MAX;
      w_dxn_nxt = 1'b1;
    end
    if (w_ny <= 11'sd0) begin
      w_ny      = '0;
      w_dyn_nxt = ~w_sel_dyn;
    end else if (w_ny >= Y_MAX) begin
      w_ny      = Y_MAX;
      w_dyn_nxt = ~w_sel_dyn;
    end
  end

  // Carry still set after the last digit means all nines: hold the score.
  always_comb begin
    w_score_inc = r_score;
    w_carry     = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (w_carry) begin
        if (r_score[4*d +: 4] == 4'd9) begin
          w_score_inc[4*d +: 4] = 4'd0;
        end else begin
          w_score_inc[4*d +: 4] = r_score[4*d +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
    if (w_carry) w_score_inc = r_score;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick      = i_vsync & ~r_vs;
    w_last      = (r_idx == 3'(N_BALLS - 1));
    unique case (r_state)
      StIdle:   if (w_tick) w_state_nxt = StUpdate;
      StUpdate: begin
        if (w_sel_en && w_miss && r_lives == 4'd1) w_state_nxt = StOver;
        else if (w_last)                           w_state_nxt = StIdle;
      end
      StOver:   if (i_restart) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_inside   = '0;
    w_draw     = 1'b0;
    w_draw_idx = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      w_inside[i] = (i_pix_x >= r_x[i]) && (12'(i_pix_x) < 12'(r_x[i]) + 12'(BALL_SIZE)) &&
                    (i_pix_y >= r_y[i]) && (11'(i_pix_y) < 11'(r_y[i]) + 11'(BALL_SIZE));
    end
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (i_visible && i_ball_en[i] && w_inside[i]) begin
        w_draw     = 1'b1;
        w_draw_idx = 3'(i);
      end
    end
  end

  assign w_init = i_reset || (r_state == StOver && i_restart);

  always_ff @(posedge i_clk75MHz) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_vs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vs    <= i_vsync;
    end
  end

  always_ff @(posedge i_clk75MHz) begin
    if (w_init) begin
      for (int i = 0; i < N_BALLS; i++) begin
        r_x[i]      <= X_INIT;
        r_y[i]      <= y_init(i);
        r_dx_neg[i] <= 1'b0;
        r_dy_neg[i] <= (i % 2) != 0;
      end
      r_flag  <= '0;
      r_idx   <= '0;
      r_lives <= LIVES_INIT;
      r_score <= '0;
    end else begin
      for (int i = 0; i < N_BALLS; i++) begin
        if (r_state == StUpdate && r_idx == 3'(i)) r_flag[i] <= 1'b0;
        else if (i_visible && i_wall_pix && w_inside[i]) r_flag[i] <= 1'b1;
      end
      if (r_state == StUpdate) begin
        r_idx <= (w_state_nxt == StUpdate) ? r_idx + 3'd1 : 3'd0;
        if (w_sel_en) begin
          for (int i = 0; i < N_BALLS; i++) begin
            if (r_idx == 3'(i)) begin
              if (w_miss) begin
                r_x[i]      <= X_INIT;
                r_y[i]      <= y_init(i);
                r_dx_neg[i] <= 1'b0;
                r_dy_neg[i] <= (i % 2) != 0;
              end else begin
                r_x[i]      <= w_nx[10:0];
                r_y[i]      <= w_ny[9:0];
                r_dx_neg[i] <= w_dxn_nxt;
                r_dy_neg[i] <= w_dyn_nxt;
              end
            end
          end
          if (w_miss)          r_lives <= r_lives - 4'd1;
          else if (w_sel_flag) r_score <= w_score_inc;
        end
      end
    end
  end

  always_ff @(posedge i_clk75MHz) begin
    if (i_reset) begin
      r_ball_pix <= 1'b0;
      r_ball_idx <= '0;
    end else begin
      r_ball_pix <= w_draw;
      r_ball_idx <= w_draw_idx;
    end
  end

  assign o_ball_pix  = r_ball_pix;
  assign o_ball_idx  = r_ball_idx;
  assign o_hit       = (r_state == StUpdate) && w_sel_en && w_bounce;
  assign o_score     = r_score;
  assign o_lives     = r_lives;
  assign o_game_over = (r_state == StOver);
  assign o_busy      = (r_state == StUpdate);

endmodule

// File: tb/tb_multi_ball_engine.sv
// Bench for multi_ball_engine: directed phases with randomized wall hits and probes,
// checked against a per-frame behavioural model of the ball game.
module tb_multi_ball_engine;
  localparam int N   = 4;
  localparam int H   = 1024;
  localparam int V   = 768;
  localparam int BS  = 16;
  localparam int ST  = 2;
  localparam int LIV = 3;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [10:0]   i_pix_x = '0;
  logic [9:0]    i_pix_y = '0;
  logic          i_visible = 1'b0;
  logic          i_vsync = 1'b0;
  logic          i_wall_pix = 1'b0;
  logic [N-1:0]  i_ball_en = '1;
  logic          i_restart = 1'b0;
  logic          o_ball_pix;
  logic [2:0]    o_ball_idx;
  logic          o_hit;
  logic [15:0]   o_score;
  logic [3:0]    o_lives;
  logic          o_game_over;
  logic          o_busy;

  always #5 clk = ~clk;

  multi_ball_engine #(
    .N_BALLS(N), .H_RES(H), .V_RES(V), .BALL_SIZE(BS), .STEP(ST), .SCORE_DIGITS(4), .LIVES(LIV)
  ) dut (
    .i_clk75MHz (clk),
    .i_reset    (i_reset),
    .i_pix_x    (i_pix_x),
    .i_pix_y    (i_pix_y),
    .i_visible  (i_visible),
    .i_vsync    (i_vsync),
    .i_wall_pix (i_wall_pix),
    .i_ball_en  (i_ball_en),
    .i_restart  (i_restart),
    .o_ball_pix (o_ball_pix),
    .o_ball_idx (o_ball_idx),
    .o_hit      (o_hit),
    .o_score    (o_score),
    .o_lives    (o_lives),
    .o_game_over(o_game_over),
    .o_busy     (o_busy)
  );

  int checks = 0;
  int failures = 0;
  int mx[N], my[N], mdx[N], mdy[N];
  bit mflag[N];
  int mscore, mlives;
  bit mover;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit covers(input int i, input int px, input int py);
    return px >= mx[i] && px < mx[i] + BS && py >= my[i] && py < my[i] + BS;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = H / 2;
      my[i] = 64 + 128 * i;
      mdx[i] = ST;
      mdy[i] = (i % 2 == 0) ? ST : -ST;
      mflag[i] = 1'b0;
    end
    mscore = 0;
    mlives = LIV;
    mover = 1'b0;
  endtask

  // One frame of game rules, ball by ball; returns balls visited and hits scored.
  task automatic model_update(output int nb, output int nh);
    nb = 0;
    nh = 0;
    if (mover) return;
    for (int i = 0; i < N; i++) begin
      nb++;
      if (!i_ball_en[i]) begin
        mflag[i] = 1'b0;
        continue;
      end
      if (mdx[i] < 0 && mx[i] <= ST) begin
        mx[i] = H / 2;
        my[i] = 64 + 128 * i;
        mdx[i] = ST;
        mdy[i] = (i % 2 == 0) ? ST : -ST;
        mflag[i] = 1'b0;
        mlives--;
        if (mlives == 0) begin
          mover = 1'b1;
          break;
        end
        continue;
      end
      if (mflag[i]) begin
        mdx[i] = -mdx[i];
        nh++;
        if (mscore < 9999) mscore++;
      end
      mflag[i] = 1'b0;
      mx[i] += mdx[i];
      my[i] += mdy[i];
      if (mx[i] >= H - BS) begin
        mx[i] = H - BS;
        mdx[i] = -ST;
      end
      if (my[i] <= 0) begin
        my[i] = 0;
        mdy[i] = -mdy[i];
      end else if (my[i] >= V - BS) begin
        my[i] = V - BS;
        mdy[i] = -mdy[i];
      end
    end
  endtask

  task automatic drive_pix(input int px, input int py, input bit vis, input bit wall,
                           input bit check);
    bit ep;
    int ei;
    i_pix_x = 11'(px);
    i_pix_y = 10'(py);
    i_visible = vis;
    i_wall_pix = wall;
    step();
    if (vis && wall) begin
      for (int i = 0; i < N; i++) if (covers(i, px, py)) mflag[i] = 1'b1;
    end
    ep = 1'b0;
    ei = 0;
    if (vis) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i_ball_en[i] && covers(i, px, py)) begin
          ep = 1'b1;
          ei = i;
        end
      end
    end
    if (check) begin
      chk("ball_pix", 32'(o_ball_pix), 32'(ep));
      chk("ball_idx", 32'(o_ball_idx), 32'(ei));
    end
  endtask

  task automatic probe_ball(input int i);
    drive_pix(mx[i], my[i], 1'b1, 1'b0, 1'b1);
    drive_pix(mx[i] + BS - 1, my[i] + BS - 1, 1'b1, 1'b0, 1'b1);
    drive_pix(mx[i] + BS, my[i] + BS - 1, 1'b1, 1'b0, 1'b1);
    if (mx[i] > 0) drive_pix(mx[i] - 1, my[i], 1'b1, 1'b0, 1'b1);
    drive_pix(mx[i], my[i], 1'b0, 1'b0, 1'b1);
  endtask

  task automatic frame(input bit check);
    int nb, nh, eb, eh;
    i_visible = 1'b0;
    i_wall_pix = 1'b0;
    i_vsync = 1'b1;
    step();
    i_vsync = 1'b0;
    nb = 0;
    nh = 0;
    for (int c = 0; c < N + 3; c++) begin
      if (o_busy) nb++;
      if (o_hit) nh++;
      step();
    end
    model_update(eb, eh);
    if (check) begin
      chk("busy_cycles", 32'(nb), 32'(eb));
      chk("hit_pulses", 32'(nh), 32'(eh));
      chk("score", 32'(o_score), 32'(to_bcd(mscore)));
      chk("lives", 32'(o_lives), 32'(mlives));
      chk("game_over", 32'(o_game_over), 32'(mover));
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    chk("rst_ball_pix", 32'(o_ball_pix), 32'd0);
    chk("rst_ball_idx", 32'(o_ball_idx), 32'd0);
    chk("rst_hit", 32'(o_hit), 32'd0);
    chk("rst_score", 32'(o_score), 32'd0);
    chk("rst_lives", 32'(o_lives), 32'(LIV));
    chk("rst_game_over", 32'(o_game_over), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    step();
    i_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int px, py, b;
    model_reset();
    step();
    do_reset();
    for (int i = 0; i < N; i++) probe_ball(i);

    // First frame from reset: plain motion of every ball.
    frame(1'b1);
    for (int i = 0; i < N; i++) probe_ball(i);

    // Wall hit on ball0 straight after reset, then single hits up to score 10.
    do_reset();
    drive_pix(mx[0] + 3, my[0] + 3, 1'b1, 1'b1, 1'b1);
    frame(1'b1);
    probe_ball(0);
    for (int f = 0; f < 20 && mscore < 10; f++) begin
      drive_pix(mx[0] + 1, my[0] + 1, 1'b1, 1'b1, 1'b0);
      frame(1'b1);
    end
    chk("score_ten", 32'(o_score), 32'h0010);

    // Hit every ball each frame until the score saturates.
    for (int f = 0; f < 3000 && mscore < 9999; f++) begin
      for (int i = 0; i < N; i++) drive_pix(mx[i] + 1, my[i] + 1, 1'b1, 1'b1, 1'b0);
      frame(1'b0);
    end
    chk("score_sat", 32'(o_score), 32'h9999);
    for (int i = 0; i < N; i++) drive_pix(mx[i] + 1, my[i] + 1, 1'b1, 1'b1, 1'b0);
    frame(1'b1);

    // Restart outside game over must be ignored.
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    chk("restart_ignored_score", 32'(o_score), 32'(to_bcd(mscore)));
    chk("restart_ignored_lives", 32'(o_lives), 32'(mlives));

    // Free run until lives run out; balls about to miss also carry a wall flag.
    for (int f = 0; f < 3000 && !mover; f++) begin
      for (int i = 0; i < N; i++) begin
        if (mdx[i] < 0 && mx[i] <= ST) drive_pix(mx[i] + 1, my[i] + 1, 1'b1, 1'b1, 1'b1);
        else if (mdx[i] > 0 && $urandom_range(15, 0) == 0)
          drive_pix(mx[i] + 1, my[i] + 1, 1'b1, 1'b1, 1'b1);
      end
      b = int'($urandom_range(N - 1, 0));
      px = mx[b] + int'($urandom_range(19, 0)) - 2;
      py = my[b] + int'($urandom_range(19, 0)) - 2;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      drive_pix(px, py, $urandom_range(3, 0) != 0, 1'b0, 1'b1);
      frame(1'b1);
    end
    chk("over_reached", 32'(o_game_over), 32'd1);

    // Frozen while over, drawing continues.
    for (int f = 0; f < 3; f++) frame(1'b1);
    for (int i = 0; i < N; i++) probe_ball(i);

    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    model_reset();
    chk("restart_lives", 32'(o_lives), 32'(LIV));
    chk("restart_score", 32'(o_score), 32'd0);
    chk("restart_over", 32'(o_game_over), 32'd0);

    // Balls 0 and 1 converge vertically; the overlap must show index 0.
    for (int f = 0; f < 40; f++) begin
      if ((my[1] - my[0]) < BS && (my[0] - my[1]) < BS) break;
      frame(1'b1);
    end
    drive_pix(mx[1], (my[0] > my[1]) ? my[0] : my[1], 1'b1, 1'b0, 1'b1);
    chk("overlap_idx0", 32'(o_ball_idx), 32'd0);
    chk("overlap_pix", 32'(o_ball_pix), 32'd1);

    // Reset in the middle of an update sequence.
    drive_pix(mx[0] + 1, my[0] + 1, 1'b1, 1'b1, 1'b1);
    frame(1'b1);
    drive_pix(mx[2] + 1, my[2] + 1, 1'b1, 1'b1, 1'b1);
    i_visible = 1'b0;
    i_wall_pix = 1'b0;
    i_vsync = 1'b1;
    step();
    i_vsync = 1'b0;
    step();
    step();
    chk("busy_at_ball2", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    model_reset();
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_hit", 32'(o_hit), 32'd0);
    chk("midrst_score", 32'(o_score), 32'd0);
    chk("midrst_lives", 32'(o_lives), 32'(LIV));
    chk("midrst_ball_pix", 32'(o_ball_pix), 32'd0);
    for (int i = 0; i < N; i++) probe_ball(i);

    // Ball1 disabled: never drawn, never moved.
    i_ball_en = 4'b1101;
    probe_ball(1);
    for (int f = 0; f < 3; f++) frame(1'b1);
    probe_ball(1);
    i_ball_en = '1;
    probe_ball(1);
    drive_pix(H / 2, 64 + 128, 1'b1, 1'b0, 1'b1);
    chk("ball1_unmoved_idx", 32'(o_ball_idx), 32'd1);
    frame(1'b1);
    for (int i = 0; i < N; i++) probe_ball(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
